// File: rtl/axis_pool_stream.sv
// rtl/axis_pool_stream.sv - kw-beat max/avg pooling over a cgu lane vector with group padding and 2-entry output skid
module axis_pool_stream #(
    parameter int UNITS      = 8,
    parameter int GROUPS     = 2,
    parameter int COPIES     = 2,
    parameter int WORD_WIDTH = 8,
    parameter int KW_MAX     = 4,
    parameter int BITS_SH    = 3,
    parameter int PAD        = 1,
    parameter logic [WORD_WIDTH-1:0] PAD_VALUE = '0,
    localparam int BITS_KW   = $clog2(KW_MAX),
    localparam int L         = COPIES * GROUPS * UNITS,
    localparam int LO        = COPIES * GROUPS * (UNITS + 2 * PAD)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [L*WORD_WIDTH-1:0]       s_axis_tdata,
    input  logic [L-1:0]                  s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic [BITS_KW+BITS_SH:0]      s_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [LO*WORD_WIDTH-1:0]      m_axis_tdata,
    output logic [LO-1:0]                 m_axis_tkeep,
    output logic                          m_axis_tlast
);
    localparam int W  = WORD_WIDTH;
    localparam int AW = W + BITS_KW;
    localparam int CW = BITS_KW + 1;
    localparam int GW = UNITS + 2 * PAD;
    localparam logic signed [AW-1:0] SAT_HI = {{(BITS_KW+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(BITS_KW+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [CW-1:0]            kw_q, kw_d, col_q, col_d;
    logic [BITS_SH-1:0]       shift_q, shift_d;
    logic [L-1:0][AW-1:0]     acc_q, acc_d;
    logic [L-1:0]             kor_q, kor_d;
    logic [1:0][LO*W-1:0]     ent_data_q, ent_data_d;
    logic [1:0][LO-1:0]       ent_keep_q, ent_keep_d;
    logic [1:0]               ent_last_q, ent_last_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     s_ready_q, s_ready_d;

    logic                     accept, first, load, close, cur_mode, pop;
    logic [CW-1:0]            kw_req, cur_kw, cur_col;
    logic [BITS_SH-1:0]       cur_shift;
    logic [L-1:0][AW-1:0]     nacc;
    logic [L-1:0]             nkor;
    logic [LO*W-1:0]          pool_data;
    logic [LO-1:0]            pool_keep;

    function automatic logic [AW-1:0] sx(input logic [W-1:0] v);
        return {{BITS_KW{v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] finish_word(input logic avg, input logic [AW-1:0] acc,
                                                 input logic kept, input logic [BITS_SH-1:0] sh);
        logic signed [AW-1:0] s;
        s = $signed(acc) >>> sh;
        if (!kept)         return '0;
        if (!avg)          return acc[W-1:0];
        if (s > SAT_HI)    return SAT_HI[W-1:0];
        if (s < SAT_LO)    return SAT_LO[W-1:0];
        return s[W-1:0];
    endfunction

    // Window control: effective config (fresh from tuser on a row's first beat) and close decision
    always_comb begin
        first  = (state_q == S_IDLE);
        load   = first || (col_q == '0);
        kw_req = CW'(s_axis_tuser[BITS_KW:1]) + CW'(1);
        if (kw_req > CW'(KW_MAX)) kw_req = CW'(KW_MAX);
        cur_mode  = first ? s_axis_tuser[0] : mode_q;
        cur_kw    = first ? kw_req : kw_q;
        cur_shift = first ? s_axis_tuser[BITS_KW+BITS_SH:BITS_KW+1] : shift_q;
        cur_col   = load ? CW'(1) : col_q + CW'(1);
        accept    = s_axis_tvalid && s_ready_q;
        close     = accept && ((cur_col == cur_kw) || s_axis_tlast);
    end

    // Per-lane fold of the incoming beat, then reduction and padding of the would-be result
    always_comb begin
        nacc      = acc_q;
        nkor      = kor_q;
        pool_data = '0;
        pool_keep = '0;
        for (int i = 0; i < L; i++) begin
            if (load) begin
                nacc[i] = s_axis_tkeep[i] ? sx(s_axis_tdata[i*W +: W]) : '0;
                nkor[i] = s_axis_tkeep[i];
            end else begin
                nkor[i] = kor_q[i] | s_axis_tkeep[i];
                if (cur_mode)
                    nacc[i] = acc_q[i] + (s_axis_tkeep[i] ? sx(s_axis_tdata[i*W +: W]) : '0);
                else if (s_axis_tkeep[i] &&
                         (!kor_q[i] || ($signed(sx(s_axis_tdata[i*W +: W])) > $signed(acc_q[i]))))
                    nacc[i] = sx(s_axis_tdata[i*W +: W]);
            end
        end
        for (int cg = 0; cg < COPIES * GROUPS; cg++) begin
            for (int w = 0; w < GW; w++) begin
                if (w < PAD || w >= UNITS + PAD) begin
                    pool_data[(cg*GW+w)*W +: W] = PAD_VALUE;
                    pool_keep[cg*GW+w]          = nkor[cg*UNITS];
                end else begin
                    pool_data[(cg*GW+w)*W +: W] = finish_word(cur_mode, nacc[cg*UNITS+w-PAD],
                                                              nkor[cg*UNITS+w-PAD], cur_shift);
                    pool_keep[cg*GW+w]          = nkor[cg*UNITS+w-PAD];
                end
            end
        end
    end

    // Next state of the FSM, latched row config and accumulators
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        kw_d    = kw_q;
        shift_d = shift_q;
        col_d   = col_q;
        acc_d   = acc_q;
        kor_d   = kor_q;
        if (accept) begin
            acc_d = nacc;
            kor_d = nkor;
            if (first) begin
                mode_d  = cur_mode;
                kw_d    = cur_kw;
                shift_d = cur_shift;
            end
            col_d   = close ? '0 : cur_col;
            state_d = s_axis_tlast ? S_IDLE : S_ACC;
        end
    end

    // Skid buffer: pop shifts entry 1 forward, push lands in the first free slot
    always_comb begin
        pop        = (cnt_q != 2'd0) && m_axis_tready;
        ent_data_d = ent_data_q;
        ent_keep_d = ent_keep_q;
        ent_last_d = ent_last_q;
        cnt_d      = cnt_q;
        if (pop) begin
            ent_data_d[0] = ent_data_q[1];
            ent_keep_d[0] = ent_keep_q[1];
            ent_last_d[0] = ent_last_q[1];
            cnt_d         = cnt_q - 2'd1;
        end
        if (close) begin
            if (cnt_d == 2'd0) begin
                ent_data_d[0] = pool_data;
                ent_keep_d[0] = pool_keep;
                ent_last_d[0] = s_axis_tlast;
            end else begin
                ent_data_d[1] = pool_data;
                ent_keep_d[1] = pool_keep;
                ent_last_d[1] = s_axis_tlast;
            end
            cnt_d = cnt_d + 2'd1;
        end
        s_ready_d = (cnt_d <= 2'd1);
    end

    // Register all state; reset drops partial windows and buffered results
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            kw_q       <= '0;
            shift_q    <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            kor_q      <= '0;
            ent_data_q <= '0;
            ent_keep_q <= '0;
            ent_last_q <= '0;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            kw_q       <= kw_d;
            shift_q    <= shift_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            kor_q      <= kor_d;
            ent_data_q <= ent_data_d;
            ent_keep_q <= ent_keep_d;
            ent_last_q <= ent_last_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = ent_data_q[0];
    assign m_axis_tkeep  = ent_keep_q[0];
    assign m_axis_tlast  = ent_last_q[0];
endmodule

// File: tb/tb_axis_pool_stream.sv
// tb/tb_axis_pool_stream.sv - self-checking bench for axis_pool_stream
module tb_axis_pool_stream;
    localparam int U = 8, G = 2, C = 2, W = 8, KWM = 4, BSH = 3, P = 1;
    localparam int BKW = 2, L = C*G*U, GW = U + 2*P, LO = C*G*GW, UW = 1 + BKW + BSH;

    logic              clk = 1'b0, areset;
    logic              s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [L*W-1:0]    s_tdata;
    logic [L-1:0]      s_tkeep;
    logic [UW-1:0]     s_tuser;
    logic [LO*W-1:0]   m_tdata;
    logic [LO-1:0]     m_tkeep;

    axis_pool_stream #(.UNITS(U), .GROUPS(G), .COPIES(C), .WORD_WIDTH(W), .KW_MAX(KWM),
                       .BITS_SH(BSH), .PAD(P), .PAD_VALUE(8'd0)) dut (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LO*W-1:0] d;
        logic [LO-1:0]   k;
        logic            l;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    pass_cnt = 0, total_cnt = 0;
    int    beat_val[L];
    bit    beat_keep[L];

    bit    row_on = 0;
    int    m_mode, m_kw, m_sh, win_n = 0;
    int    win_v[KWM][L];
    bit    win_k[KWM][L];

    task automatic check_int(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ow(int n, int o);
        beat_t b;
        logic signed [W-1:0] t;
        if (n >= obs_q.size()) return -999;
        b = obs_q[n];
        t = b.d[o*W +: W];
        return int'(t);
    endfunction

    function automatic int okeep(int n, int o);
        beat_t b;
        if (n >= obs_q.size()) return -1;
        b = obs_q[n];
        return int'(b.k[o]);
    endfunction

    function automatic int olast(int n);
        beat_t b;
        if (n >= obs_q.size()) return -1;
        b = obs_q[n];
        return int'(b.l);
    endfunction

    // Reference: reduce the collected window beats per lane, then lay out padded groups
    task automatic model_close(bit last);
        beat_t e;
        int    vals[L];
        bit    kept[L];
        for (int i = 0; i < L; i++) begin
            int r, mx, sum;
            bit any;
            any = 0; mx = 0; sum = 0;
            for (int b = 0; b < win_n; b++) begin
                if (win_k[b][i]) begin
                    sum += win_v[b][i];
                    if (!any || win_v[b][i] > mx) mx = win_v[b][i];
                    any = 1;
                end
            end
            if (m_mode == 0) r = mx;
            else begin
                r = sum >>> m_sh;
                if (r > 127) r = 127;
                if (r < -128) r = -128;
            end
            if (!any) r = 0;
            vals[i] = r;
            kept[i] = any;
        end
        e.d = '0; e.k = '0; e.l = last;
        for (int cg = 0; cg < C*G; cg++) begin
            for (int w = 0; w < GW; w++) begin
                if (w < P || w >= U + P) begin
                    e.d[(cg*GW+w)*W +: W] = 8'd0;
                    e.k[cg*GW+w]          = kept[cg*U];
                end else begin
                    e.d[(cg*GW+w)*W +: W] = 8'(vals[cg*U+w-P]);
                    e.k[cg*GW+w]          = kept[cg*U+w-P];
                end
            end
        end
        exp_q.push_back(e);
        win_n = 0;
    endtask

    task automatic model_accept(bit last, logic [UW-1:0] user);
        if (!row_on) begin
            m_mode = int'(user[0]);
            m_kw   = int'(user[2:1]) + 1;
            if (m_kw > KWM) m_kw = KWM;
            m_sh   = int'(user[5:3]);
            row_on = 1;
            win_n  = 0;
        end
        for (int i = 0; i < L; i++) begin
            win_v[win_n][i] = beat_val[i];
            win_k[win_n][i] = beat_keep[i];
        end
        win_n++;
        if (win_n == m_kw || last) model_close(last);
        if (last) row_on = 0;
    endtask

    task automatic fill(int base);
        for (int i = 0; i < L; i++) begin
            beat_val[i]  = ((base*37 + i*11) % 200) - 100;
            beat_keep[i] = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(bit last, logic [UW-1:0] user);
        int n;
        for (int i = 0; i < L; i++) begin
            s_tdata[i*W +: W] = 8'(beat_val[i]);
            s_tkeep[i]        = beat_keep[i];
        end
        s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 100) begin
                total_cnt++;
                $display("FAIL send_timeout: got tready=0 for %0d cycles expected 1", n);
                s_tvalid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(last, user);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic beat0(int base, int v0, bit last, logic [UW-1:0] user);
        fill(base);
        beat_val[0] = v0;
        send_beat(last, user);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_int("drain_empty", exp_q.size(), 0);
    endtask

    // Compare process: every popped output against the model, plus hold stability under backpressure
    beat_t hold, e;
    bit    held = 0;
    always @(negedge clk) begin
        if (areset) held = 0;
        else begin
            if (held) begin
                total_cnt++;
                if (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tlast} !== hold)
                    $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", m_tvalid, {m_tdata, m_tkeep, m_tlast}, hold);
                else pass_cnt++;
            end
            held = 0;
            if (m_tvalid) begin
                if (m_tready) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_out: got output %h expected none", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        total_cnt += 3;
                        if (m_tdata === e.d) pass_cnt++;
                        else $display("FAIL out_data: got %h expected %h", m_tdata, e.d);
                        if (m_tkeep === e.k) pass_cnt++;
                        else $display("FAIL out_keep: got %h expected %h", m_tkeep, e.k);
                        if (m_tlast === e.l) pass_cnt++;
                        else $display("FAIL out_last: got %0b expected %0b", m_tlast, e.l);
                        obs_q.push_back({m_tdata, m_tkeep, m_tlast});
                    end
                end else begin
                    held = 1;
                    hold = {m_tdata, m_tkeep, m_tlast};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; m_tready = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_m_tvalid", int'(m_tvalid), 0);
        check_int("rst_m_tdata_zero", int'(m_tdata == '0), 1);
        check_int("rst_m_tkeep_zero", int'(m_tkeep == '0), 1);
        check_int("rst_m_tlast", int'(m_tlast), 0);
        check_int("rst_s_tready", int'(s_tready), 0);
        @(posedge clk); #1; areset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_int("tready_after_rst", int'(s_tready), 1);
        @(posedge clk); #1;

        // Max, kw=2: lane0 3,-5,7,2
        obs_q.delete();
        beat0(1, 3, 0, 6'd2); beat0(2, -5, 0, 6'd2); beat0(3, 7, 0, 6'd2); beat0(4, 2, 1, 6'd2);
        drain();
        check_int("max_kw2_out0", ow(0, 1), 3);
        check_int("max_kw2_out1", ow(1, 1), 7);
        check_int("max_kw2_last0", olast(0), 0);
        check_int("max_kw2_last1", olast(1), 1);
        check_int("pad_left_data", ow(0, 0), 0);
        check_int("pad_left_keep", okeep(0, 0), 1);
        check_int("pad_right_keep", okeep(0, 9), 1);

        // Avg kw=4 shift=2, then saturation at both ends with shift=0
        obs_q.delete();
        for (int k = 0; k < 4; k++) beat0(10 + k, 100, k == 3, 6'd23);
        for (int k = 0; k < 4; k++) begin
            fill(20 + k); beat_val[0] = 127; beat_val[1] = -128;
            send_beat(k == 3, 6'd7);
        end
        drain();
        check_int("avg_100", ow(0, 1), 100);
        check_int("avg_sat_hi", ow(1, 1), 127);
        check_int("avg_sat_lo", ow(1, 2), -128);

        // Max kw=3 partial window at tlast, then a kw=1 row
        obs_q.delete();
        beat0(30, 1, 0, 6'd4); beat0(31, 9, 0, 6'd4); beat0(32, 4, 0, 6'd4); beat0(33, -2, 1, 6'd4);
        beat0(34, 5, 0, 6'd0); beat0(35, 6, 1, 6'd0);
        drain();
        check_int("kw3_full", ow(0, 1), 9);
        check_int("kw3_full_last", olast(0), 0);
        check_int("kw3_partial", ow(1, 1), -2);
        check_int("kw3_partial_last", olast(1), 1);
        check_int("kw1_first", ow(2, 1), 5);
        check_int("kw1_second", ow(3, 1), 6);
        check_int("kw1_second_last", olast(3), 1);

        // Keep masking on lane5, and unit0 of group (1,0) masked for pad keep
        obs_q.delete();
        fill(40); beat_keep[5] = 0; send_beat(0, 6'd2);
        fill(41); beat_keep[5] = 0; send_beat(0, 6'd2);
        fill(42); beat_keep[5] = 0; beat_keep[16] = 0; send_beat(0, 6'd2);
        fill(43); beat_val[5] = 42; beat_keep[16] = 0; send_beat(1, 6'd2);
        drain();
        check_int("keep0_data", ow(0, 6), 0);
        check_int("keep0_keep", okeep(0, 6), 0);
        check_int("keep1_data", ow(1, 6), 42);
        check_int("keep1_keep", okeep(1, 6), 1);
        check_int("padkeep_left_off", okeep(1, 20), 0);
        check_int("padkeep_right_off", okeep(1, 29), 0);

        // Backpressure: 10 cycles of m_tready=0 while streaming kw=1
        obs_q.delete();
        m_tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) beat0(50 + k, k*10, k == 5, 6'd0);
            end
            begin
                repeat (10) @(negedge clk);
                check_int("bp_tready_low", int'(s_tready), 0);
                check_int("bp_tvalid_held", int'(m_tvalid), 1);
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        drain();
        check_int("bp_count", obs_q.size(), 6);
        for (int k = 0; k < 6; k++) check_int("bp_order", ow(k, 1), k*10);

        // Reset with one buffered result and a half-built window
        obs_q.delete();
        m_tready = 1'b0;
        beat0(60, 11, 0, 6'd2); beat0(61, 12, 0, 6'd2); beat0(62, 13, 0, 6'd2);
        check_int("pre_rst_tvalid", int'(m_tvalid), 1);
        areset = 1'b1;
        exp_q.delete(); row_on = 0; win_n = 0;
        @(posedge clk); @(negedge clk);
        check_int("mid_rst_tvalid", int'(m_tvalid), 0);
        check_int("mid_rst_tready", int'(s_tready), 0);
        @(posedge clk); #1;
        areset = 1'b0; m_tready = 1'b1;
        @(posedge clk); #1;
        beat0(70, 20, 0, 6'd2); beat0(71, 30, 1, 6'd2);
        drain();
        check_int("post_rst_count", obs_q.size(), 1);
        check_int("post_rst_value", ow(0, 1), 30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
